// File: rtl/rca_pkg.sv
// rca_pkg: shared FSM state type and default sizing for the rca_acc summing block
package rca_pkg;
  localparam int WIDTH = 9;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

// File: rtl/rca_acc_if.sv
// rca_acc_if: start, operand and result handshake bundle of rca_acc
interface rca_acc_if
  import rca_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int cnt_w = CNT_W
);
  logic                   start_i;
  logic [cnt_w-1:0]       len_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [width-1:0]       data_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [width+cnt_w-1:0] sum_o;
  logic                   busy_o;
  modport master (
    output start_i, len_i, in_valid_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, busy_o
  );
  modport slave (
    input  start_i, len_i, in_valid_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, busy_o
  );
endinterface

// File: rtl/rca.sv
// rca: combinational ripple-carry adder
module rca
  import rca_pkg::*;
#(
  parameter int n = WIDTH + CNT_W
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic         ci_i,
  output logic [n-1:0] sum_o,
  output logic         co_o
);
  logic [n:0] w_c;
  assign w_c[0] = ci_i;
  for (genvar i = 0; i < n; i++) begin : g_bit
    assign sum_o[i]  = a_i[i] ^ b_i[i] ^ w_c[i];
    assign w_c[i+1]  = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
  end
  assign co_o = w_c[n];
endmodule

// File: rtl/rca_acc.sv
// rca_acc: sums len_i operands through a ripple-carry adder and hands off the result
module rca_acc
  import rca_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int cnt_w = CNT_W
) (
  input logic   clk_i,
  input logic   rst_ni,
  rca_acc_if.slave bus
);
  localparam int acc_w = width + cnt_w;
  state_t             r_state, w_next;
  logic [acc_w-1:0]   r_acc, w_sum;
  logic [cnt_w-1:0]   r_cnt, r_len;
  logic               w_take, w_last, w_co;
  assign w_take = (r_state == ACC) && bus.in_valid_i;
  assign w_last = r_cnt == r_len - 1'b1;
  rca #(.n(acc_w)) u_add (
    .a_i  (r_acc),
    .b_i  ({{cnt_w{1'b0}}, bus.data_i}),
    .ci_i (1'b0),
    .sum_o(w_sum),
    .co_o (w_co)
  );
  always_ff @(posedge clk_i) r_state <= !rst_ni ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start_i ? (|bus.len_i ? ACC : DONE) : IDLE;
      ACC:     w_next = (w_take && w_last) ? DONE : ACC;
      DONE:    w_next = bus.out_ready_i ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready_o  = r_state == ACC;
    bus.out_valid_o = r_state == DONE;
    bus.busy_o      = r_state != IDLE;
    bus.sum_o       = r_acc;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
    end else if (r_state == IDLE && bus.start_i) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= bus.len_i;
    end else if (w_take) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end
  // acc_w is sized so the adder carry-out can never be set
  always_ff @(posedge clk_i) if (rst_ni && w_take) assert (!w_co);
endmodule

// File: tb/tb_rca_acc.sv
// tb_rca_acc: scoreboard-driven bench for the rca_acc summing block
module tb_rca_acc;
  import rca_pkg::*;
  localparam int ACC_W = WIDTH + CNT_W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [ACC_W-1:0] sb[$];
  always #5 clk = ~clk;
  rca_acc_if bus ();
  rca_acc dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int len, input int ops[16]);
    int s = 0;
    for (int k = 0; k < len; k++) s += ops[k];
    sb.push_back(ACC_W'(s));
    bus.start_i = 1'b1;
    bus.len_i = CNT_W'(len);
    step;
    bus.start_i = 1'b0;
  endtask

  task automatic feed(input int len, input int ops[16], input int mode, output int hs);
    int cyc = 0;
    hs = 0;
    while (hs < len && cyc < 400) begin
      bus.in_valid_i = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bus.data_i = WIDTH'(ops[hs]);
      if (bus.in_valid_i && bus.in_ready_o) hs++;
      step;
      cyc++;
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic consume;
    bus.out_ready_i = 1'b1;
    step;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step;
    step;
    n_vec++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.busy_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: ready/valid/busy=%b expected 000", {bus.in_ready_o, bus.out_valid_o, bus.busy_o});
    end
    n_vec++;
    if (bus.sum_o !== '0) begin
      n_err++;
      $display("FAIL reset_sum: sum_o=%0d expected 0", bus.sum_o);
    end
    rst_n = 1'b1;
    step;
    n_vec++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.sum_o} !== {3'b000, ACC_W'(0)}) begin
      n_err++;
      $display("FAIL reset_after: ready/valid/busy=%b sum_o=%0d expected 000 and 0", {bus.in_ready_o, bus.out_valid_o, bus.busy_o}, bus.sum_o);
    end
  endtask

  task automatic test_basic;
    int ops[16] = '{default: 511};
    int hs;
    logic [ACC_W-1:0] exp;
    start_run(3, ops);
    n_vec++;
    if (bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL basic_acc_state: in_ready_o=%b busy_o=%b expected 1 1", bus.in_ready_o, bus.busy_o);
    end
    feed(3, ops, 0, hs);
    n_vec++;
    if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL basic_latency: out_valid_o=%b in_ready_o=%b expected 1 0", bus.out_valid_o, bus.in_ready_o);
    end
    exp = sb.pop_front();
    n_vec++;
    if (bus.sum_o !== exp) begin
      n_err++;
      $display("FAIL basic_sum: sum_o=%0d expected %0d", bus.sum_o, exp);
    end
    consume;
    n_vec++;
    if ({bus.busy_o, bus.out_valid_o} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_idle: busy/valid=%b expected 00", {bus.busy_o, bus.out_valid_o});
    end
  endtask

  task automatic test_len0;
    int ops[16] = '{default: 0};
    logic [ACC_W-1:0] exp;
    start_run(0, ops);
    exp = sb.pop_front();
    n_vec++;
    if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.sum_o !== exp) begin
      n_err++;
      $display("FAIL len0_result: valid=%b ready=%b sum_o=%0d expected 1 0 %0d", bus.out_valid_o, bus.in_ready_o, bus.sum_o, exp);
    end
    consume;
    n_vec++;
    if (bus.in_ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL len0_idle: ready=%b busy=%b expected 0 0", bus.in_ready_o, bus.busy_o);
    end
  endtask

  task automatic test_stall;
    int ops[16] = '{default: 511};
    int hs;
    logic [ACC_W-1:0] exp;
    start_run(15, ops);
    feed(15, ops, 1, hs);
    n_vec++;
    if (hs != 15) begin
      n_err++;
      $display("FAIL stall_handshakes: got %0d expected 15", hs);
    end
    n_vec++;
    if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_done: valid=%b ready=%b expected 1 0", bus.out_valid_o, bus.in_ready_o);
    end
    exp = sb.pop_front();
    n_vec++;
    if (bus.sum_o !== exp) begin
      n_err++;
      $display("FAIL stall_sum: sum_o=%0d expected %0d", bus.sum_o, exp);
    end
    consume;
  endtask

  task automatic test_hold;
    int ops[16] = '{0: 100, 1: 23, default: 0};
    int hs;
    logic [ACC_W-1:0] exp;
    start_run(2, ops);
    feed(2, ops, 0, hs);
    exp = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      bus.start_i = (c % 2 == 0);
      bus.len_i = CNT_W'(5);
      n_vec++;
      if (bus.out_valid_o !== 1'b1 || bus.sum_o !== exp) begin
        n_err++;
        $display("FAIL hold_stable cycle %0d: valid=%b sum_o=%0d expected 1 %0d", c, bus.out_valid_o, bus.sum_o, exp);
      end
      step;
    end
    bus.start_i = 1'b1;
    bus.out_ready_i = 1'b1;
    step;
    bus.start_i = 1'b0;
    bus.out_ready_i = 1'b0;
    n_vec++;
    if (bus.busy_o !== 1'b0 || bus.out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL hold_start_ignored: busy=%b valid=%b expected 0 0", bus.busy_o, bus.out_valid_o);
    end
    step;
    n_vec++;
    if (bus.busy_o !== 1'b0 || bus.sum_o !== exp) begin
      n_err++;
      $display("FAIL hold_idle: busy=%b sum_o=%0d expected 0 %0d", bus.busy_o, bus.sum_o, exp);
    end
  endtask

  task automatic test_reset_mid;
    int ops[16] = '{0: 7, 1: 8, 2: 9, 3: 10, default: 0};
    int hs;
    logic seen = 1'b0;
    logic [ACC_W-1:0] exp;
    start_run(4, ops);
    feed(2, ops, 0, hs);
    void'(sb.pop_back());
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    n_vec++;
    if ({bus.busy_o, bus.out_valid_o, bus.in_ready_o} !== 3'b000 || bus.sum_o !== '0) begin
      n_err++;
      $display("FAIL midreset_state: busy/valid/ready=%b sum_o=%0d expected 000 0", {bus.busy_o, bus.out_valid_o, bus.in_ready_o}, bus.sum_o);
    end
    repeat (3) begin
      seen |= bus.out_valid_o;
      step;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_no_output: out_valid_o seen=%b expected 0", seen);
    end
    ops = '{0: 1, 1: 2, default: 0};
    start_run(2, ops);
    feed(2, ops, 0, hs);
    exp = sb.pop_front();
    n_vec++;
    if (bus.out_valid_o !== 1'b1 || bus.sum_o !== exp) begin
      n_err++;
      $display("FAIL midreset_fresh: valid=%b sum_o=%0d expected 1 %0d", bus.out_valid_o, bus.sum_o, exp);
    end
    consume;
  endtask

  task automatic test_back_to_back;
    int ops[16];
    int hs;
    logic [ACC_W-1:0] exp;
    for (int r = 0; r < 1000; r++) begin
      int len = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++) ops[k] = $urandom_range(0, 511);
      start_run(len, ops);
      feed(len, ops, 2, hs);
      exp = sb.pop_front();
      n_vec++;
      if (bus.out_valid_o !== 1'b1 || hs != len || $isunknown(bus.sum_o) || bus.sum_o !== exp) begin
        n_err++;
        $display("FAIL random_run %0d: len=%0d hs=%0d valid=%b sum_o=%0d expected %0d", r, len, hs, bus.out_valid_o, bus.sum_o, exp);
      end
      repeat ($urandom_range(0, 2)) step;
      consume;
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.len_i = '0;
    bus.in_valid_i = 1'b0;
    bus.data_i = '0;
    bus.out_ready_i = 1'b0;
    test_reset;
    test_basic;
    test_len0;
    test_stall;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rca_acc.md
RCA_ACC -- requirements
Module: rca_acc

Interface
REQ-001 SHALL have parameter width, default 9: operand width in bits.
REQ-002 SHALL have parameter cnt_w, default 4: term-count width; at most 2^cnt_w-1 terms per sum.
REQ-003 SHALL derive localparam acc_w = width+cnt_w: accumulator and result width.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk_i  input  1  clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  synchronous active-low reset.
REQ-007 start_i  input  1  begin a new summation; sampled only in IDLE.
REQ-008 len_i  input  cnt_w  number of operands to sum; captured with start_i.
REQ-009 in_valid_i  input  1  data_i holds a valid operand.
REQ-010 in_ready_o  output  1  block accepts an operand this cycle.
REQ-011 data_i  input  width  unsigned operand.
REQ-012 out_valid_o  output  1  sum_o holds a completed result.
REQ-013 out_ready_i  input  1  downstream consumes the result.
REQ-014 sum_o  output  acc_w  unsigned accumulated sum.
REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, ACC, DONE.
REQ-017 IDLE: in_ready_o=0, out_valid_o=0; on start_i=1 capture len_i, clear cnt and acc; go to ACC if len_i!=0, else to DONE with acc=0.
REQ-018 ACC: in_ready_o=1; an operand is accepted when in_valid_i&&in_ready_o; acc <= acc + zero-extended data_i; cnt <= cnt+1.
REQ-019 ACC: the handshake that accepts operand number len (cnt==len-1) SHALL move to DONE on the same edge.
REQ-020 ACC: cycles with in_valid_i=0 SHALL leave acc, cnt and state unchanged.
REQ-021 DONE: out_valid_o=1, in_ready_o=0, sum_o=acc held stable until out_ready_i=1; on out_ready_i=1 go to IDLE.
REQ-022 sum_o SHALL equal acc in every state; it reads 0 after reset.
REQ-023 Latency: out_valid_o SHALL rise on the cycle after the last operand handshake; when len_i=0 it SHALL rise on the cycle after start_i.
REQ-024 start_i in ACC or DONE SHALL be ignored, including in the cycle of the output handshake; a new start is accepted only in IDLE.
REQ-025 The addition SHALL use the rca sub-module at width acc_w. Its carry-out is discarded; acc_w guarantees no overflow, because (2^cnt_w-1)*(2^width-1) < 2^acc_w.
REQ-026 Back-to-back runs are allowed: start_i may be asserted on the first cycle back in IDLE.

Reset
REQ-027 rst_ni=0 at a clock edge SHALL force IDLE, with acc, cnt and captured len set to 0.
REQ-028 Outputs during and after reset: in_ready_o=0, out_valid_o=0, busy_o=0, sum_o=0.
REQ-029 Reset asserted mid-run (ACC or DONE) SHALL discard the partial or pending result with no output handshake.

Structure
REQ-030 A shared package rca_pkg SHALL hold the FSM state typedef (IDLE, ACC, DONE) and the default width and cnt_w constants.
REQ-031 SHALL instantiate exactly one existing rca sub-module as the combinational adder: a_i = acc, b_i = zero-extended data_i, sum_o = next acc.
REQ-032 All other logic (FSM, counter, registers) SHALL live in rca_acc.

Verification
REQ-033 Defaults; start with len=3; operands 511, 511, 511, one per cycle -> out_valid_o one cycle after the third handshake; sum_o=1533.
REQ-034 start with len=0 -> out_valid_o next cycle, sum_o=0, in_ready_o never high.
REQ-035 len=15, all operands 511, in_valid_i toggling every other cycle -> exactly 15 handshakes; sum_o=7665; no overflow.
REQ-036 Result ready with out_ready_i held low for 5 cycles, start_i pulsed meanwhile -> sum_o stable, start ignored; IDLE follows the out_ready_i=1 edge.
REQ-037 rst_ni low for one cycle after 2 of 4 operands -> IDLE, sum_o=0, no out_valid_o; a fresh run with len=2, operands 1 and 2 -> sum_o=3.
REQ-038 Random len and operands over 1000 runs -> sum_o matches the reference sum every run; the bench flags any mismatch as X, matching the existing adder bench's check style.
